ad76xx_par_reader: RTL and testbench
====================================

# ad76xx_par_reader

Parametrised parallel-interface controller for AD7656-class simultaneous-sampling SAR ADCs. It issues CONVST, waits for BUSY to fall, reads NUM_CH words over CS_N/RD_N, and presents all channels together as one coherent snapshot with a valid strobe. Every interface time is set in clock cycles, and the block adds BUSY-timeout and overrun reporting. It sits between the board ADC pins and the sample-processing fabric, and replaces the fixed 6-channel driver.

## Interface
Parameters:
- DW, 16, ADC word width.
- NUM_CH, 6, channels read per conversion (1..8).
- T_CONV_HI, 4, CONVST high cycles (≥1).
- T_CS, 5, CS_N-low-to-first-RD_N-low cycles (≥1).
- T_RDL, 9, RD_N low cycles per word (≥2).
- T_RDH, 3, RD_N high cycles between words (≥1).
- BUSY_TMO, 400, cycles allowed from CONVST rise to BUSY fall (≥T_CONV_HI+4).
- T_QUIET, 8, idle cycles after a read before the next start is accepted.
- RST_CYC, 10, adc_reset_o hold cycles after rst_i deasserts.

Ports:
- sys_clk_i  in  1  system clock (100 MHz nominal).
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  conversion request, single-cycle pulse.
- trig_div_i  in  32  auto-trigger period in cycles; 0 = off (present only with macro).
- convst_o  out  1  CONVST to all ADC groups.
- busy_i  in  1  ADC BUSY, asynchronous.
- cs_n_o  out  1  chip select, active-low.
- rd_n_o  out  1  read strobe, active-low.
- adc_reset_o  out  1  ADC RESET pin, active-high.
- db_i  in  DW  ADC data bus.
- data_o  out  NUM_CH*DW  snapshot; channel k at [k*DW +: DW].
- data_valid_o  out  1  one-cycle pulse when data_o updates.
- timeout_o  out  1  one-cycle pulse on BUSY timeout.
- overrun_o  out  1  one-cycle pulse when a trigger is dropped.

## Operation
- States: IDLE → CONV → WAIT_BUSY → CS_SETUP → READ → DONE → QUIET → IDLE.
- IDLE: on a trigger (start_i, or the auto-trigger with the macro), go to CONV.
- CONV: convst_o=1 for T_CONV_HI cycles, then WAIT_BUSY.
- convst_o=0 in every other state.
- WAIT_BUSY: on a falling edge of the synchronised BUSY, go to CS_SETUP.
- WAIT_BUSY timeout: if the cycle count since entering CONV reaches BUSY_TMO, pulse timeout_o, go to IDLE, leave data_o unchanged.
- CS_SETUP: cs_n_o=0 for T_CS cycles.
- READ: for each word w=0..NUM_CH-1, rd_n_o=0 for T_RDL cycles, then 1 for T_RDH cycles.
- READ capture: db_i is latched into a staging register slot w on the last RD_N-low cycle.
- READ exit: after the T_RDH of word NUM_CH-1, go to DONE.
- cs_n_o is 0 throughout CS_SETUP and READ, and 1 elsewhere.
- DONE (1 cycle): copy staging to data_o, pulse data_valid_o, go to QUIET.
- QUIET: T_QUIET cycles, then IDLE.
- Dropped trigger: a trigger in any state other than IDLE pulses overrun_o and is discarded, never queued.
- BUSY path: busy_i passes through 2 flops; the falling edge is detected as (r2 && !r1).
- adc_reset_o is 1 while rst_i=1 and for RST_CYC cycles after it falls.
- The FSM holds in IDLE, and ignores triggers, while adc_reset_o=1.

## Timing
- Reset values: convst_o 0, cs_n_o 1, rd_n_o 1, adc_reset_o 1, data_o 0, data_valid_o 0, timeout_o 0, overrun_o 0; FSM in IDLE; all counters 0.
- Reset mid-operation: on the next edge all outputs take reset values and staging is cleared; a partial read never reaches data_o.
- start_i sampled at edge n → convst_o=1 from edge n+1.
- BUSY fall on pin → cs_n_o=0 no later than 3 cycles later (2-flop sync + 1 registered state).
- Read duration: T_CS + NUM_CH*(T_RDL+T_RDH) cycles.
- data_valid_o rises 1 cycle after the final RD_N-high cycle.
- Minimum trigger-to-trigger period: T_CONV_HI + BUSY-low latency + read duration + 1 + T_QUIET.
- Simultaneous start_i and auto-trigger in IDLE: counted as one conversion, no overrun.
- A BUSY fall seen in CONV (before WAIT_BUSY) is ignored; only falls during WAIT_BUSY count.

## Configuration
- Macro: AD76XX_AUTO_TRIG_EN.
- Defined: trig_div_i exists and a 32-bit free-running counter issues a trigger every trig_div_i cycles.
- Counter reset: it clears when it fires, on rst_i, and when trig_div_i=0.
- Undefined: no trig_div_i port, no counter; start_i is the only trigger.

## Structure
- Package ad76xx_pkg holds:
  - the state enum (3 bits);
  - default timing constants for the 100 MHz build;
  - a function returning the minimum trigger period from the parameters.
- Sub-module ad76xx_busy_sync: 2-flop synchroniser plus falling-edge detect, reset to 0.

## Test plan
- Default parameters, start_i pulse, BUSY high 200 cycles then low, db_i returns 16'h1000+w per word → data_o ch0..5 = 1000..1005, exactly one data_valid_o pulse, 6 RD_N pulses each 9 cycles low.
- BUSY never falls → timeout_o pulses at cycle 400 after CONVST rise, no data_valid_o, data_o unchanged, FSM back in IDLE.
- start_i pulsed again mid-READ → one overrun_o pulse, read completes normally, only one data_valid_o.
- rst_i asserted during word 3 → next edge cs_n_o=1, rd_n_o=1, data_o=0; adc_reset_o stays high 10 cycles after release; start_i during that window is ignored.
- Build with AD76XX_AUTO_TRIG_EN, trig_div_i=2000, BUSY 150 cycles → data_valid_o every 2000 cycles, no overrun.
- Same build, trig_div_i=100 → overrun_o on each trigger that lands mid-conversion.
- NUM_CH=8, DW=14, T_RDL=4 → 8 words captured at [k*14 +: 14].

Source files
------------

// File: rtl/ad76xx_pkg.sv
// Shared types and defaults for the AD76xx parallel reader.
// The optional auto-trigger is enabled by defining AD76XX_AUTO_TRIG_EN.
package ad76xx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_WAIT_BUSY,
    ST_CS_SETUP,
    ST_READ,
    ST_DONE,
    ST_QUIET
  } state_e;

  // Defaults for the 100 MHz build
  localparam int DEF_DW        = 16;
  localparam int DEF_NUM_CH    = 6;
  localparam int DEF_T_CONV_HI = 4;
  localparam int DEF_T_CS      = 5;
  localparam int DEF_T_RDL     = 9;
  localparam int DEF_T_RDH     = 3;
  localparam int DEF_BUSY_TMO  = 400;
  localparam int DEF_T_QUIET   = 8;
  localparam int DEF_RST_CYC   = 10;

  // Shortest trigger-to-trigger spacing that never overruns, given the
  // BUSY-low latency seen on the board (in cycles).
  function automatic int min_trig_period(input int t_conv_hi, input int busy_lat,
                                         input int num_ch, input int t_cs,
                                         input int t_rdl, input int t_rdh,
                                         input int t_quiet);
    return t_conv_hi + busy_lat + t_cs + num_ch * (t_rdl + t_rdh) + 1 + t_quiet;
  endfunction

endpackage

// File: rtl/ad76xx_busy_sync.sv
// Two-flop synchroniser for the ADC BUSY pin with falling-edge detect.
module ad76xx_busy_sync
  import ad76xx_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic busy_i,
  output logic fall_o
);

  logic r1_q, r2_q;

  // Resynchronise BUSY into the system clock domain
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r1_q <= 1'b0;
      r2_q <= 1'b0;
    end else begin
      r1_q <= busy_i;
      r2_q <= r1_q;
    end
  end

  assign fall_o = r2_q && !r1_q;

endmodule

// File: rtl/ad76xx_par_reader.sv
// Parallel-bus reader for AD7656-class ADCs: CONVST, wait BUSY, read
// NUM_CH words over CS_N/RD_N, publish one coherent snapshot.
// Define AD76XX_AUTO_TRIG_EN to add the trig_div_i periodic trigger.
module ad76xx_par_reader
  import ad76xx_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int T_CONV_HI = DEF_T_CONV_HI,
  parameter int T_CS      = DEF_T_CS,
  parameter int T_RDL     = DEF_T_RDL,
  parameter int T_RDH     = DEF_T_RDH,
  parameter int BUSY_TMO  = DEF_BUSY_TMO,
  parameter int T_QUIET   = DEF_T_QUIET,
  parameter int RST_CYC   = DEF_RST_CYC
) (
  input  logic                 sys_clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
`ifdef AD76XX_AUTO_TRIG_EN
  input  logic [31:0]          trig_div_i,
`endif
  output logic                 convst_o,
  input  logic                 busy_i,
  output logic                 cs_n_o,
  output logic                 rd_n_o,
  output logic                 adc_reset_o,
  input  logic [DW-1:0]        db_i,
  output logic [NUM_CH*DW-1:0] data_o,
  output logic                 data_valid_o,
  output logic                 timeout_o,
  output logic                 overrun_o
);

  localparam int WW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic trig;
  logic busy_fall;

  ad76xx_busy_sync u_busy_sync (
    .clk_i  (sys_clk_i),
    .rst_i  (rst_i),
    .busy_i (busy_i),
    .fall_o (busy_fall)
  );

`ifdef AD76XX_AUTO_TRIG_EN
  logic [31:0] trig_cnt_q;
  logic        auto_fire;

  // >= so that lowering trig_div_i mid-count fires at once instead of wrapping
  assign auto_fire = (trig_div_i != 32'd0) && (trig_cnt_q >= trig_div_i - 32'd1);
  assign trig      = start_i | auto_fire;

  // Free-running period counter for the auto-trigger
  always_ff @(posedge sys_clk_i) begin
    if (rst_i || trig_div_i == 32'd0 || auto_fire) trig_cnt_q <= 32'd0;
    else                                            trig_cnt_q <= trig_cnt_q + 32'd1;
  end
`else
  assign trig = start_i;
`endif

  logic        arst_q;
  logic [31:0] arst_cnt_q;

  // Hold the ADC RESET pin through reset and RST_CYC cycles beyond it
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      arst_q     <= 1'b1;
      arst_cnt_q <= 32'd0;
    end else if (arst_q) begin
      if (arst_cnt_q == 32'(RST_CYC - 1)) begin
        arst_q     <= 1'b0;
        arst_cnt_q <= 32'd0;
      end else begin
        arst_cnt_q <= arst_cnt_q + 32'd1;
      end
    end
  end

  state_e                    state_q;
  logic [31:0]               cnt_q;
  logic [31:0]               tmo_q;
  logic [WW-1:0]             w_q;
  logic [NUM_CH-1:0][DW-1:0] stage_q;
  logic [NUM_CH-1:0][DW-1:0] data_q;
  logic convst_q, cs_n_q, rd_n_q, dv_q, timeout_q, overrun_q;

  // Conversion/read sequencer; rd_n_q doubles as the low/high phase flag in READ
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 32'd0;
      tmo_q     <= 32'd0;
      w_q       <= '0;
      stage_q   <= '0;
      data_q    <= '0;
      convst_q  <= 1'b0;
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      dv_q      <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      dv_q      <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= trig && (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (trig && !arst_q) begin
            state_q  <= ST_CONV;
            convst_q <= 1'b1;
            cnt_q    <= 32'd0;
            tmo_q    <= 32'd0;
          end
        end
        ST_CONV: begin
          tmo_q <= tmo_q + 32'd1;
          if (cnt_q == 32'(T_CONV_HI - 1)) begin
            state_q  <= ST_WAIT_BUSY;
            convst_q <= 1'b0;
            cnt_q    <= 32'd0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        ST_WAIT_BUSY: begin
          tmo_q <= tmo_q + 32'd1;
          if (busy_fall) begin
            state_q <= ST_CS_SETUP;
            cs_n_q  <= 1'b0;
            cnt_q   <= 32'd0;
            tmo_q   <= 32'd0;
          end else if (tmo_q == 32'(BUSY_TMO - 1)) begin
            state_q   <= ST_IDLE;
            timeout_q <= 1'b1;
            tmo_q     <= 32'd0;
          end
        end
        ST_CS_SETUP: begin
          if (cnt_q == 32'(T_CS - 1)) begin
            state_q <= ST_READ;
            rd_n_q  <= 1'b0;
            cnt_q   <= 32'd0;
            w_q     <= '0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        ST_READ: begin
          if (!rd_n_q) begin
            if (cnt_q == 32'(T_RDL - 1)) begin
              stage_q[w_q] <= db_i;
              rd_n_q       <= 1'b1;
              cnt_q        <= 32'd0;
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end else if (cnt_q == 32'(T_RDH - 1)) begin
            cnt_q <= 32'd0;
            if (w_q == WW'(NUM_CH - 1)) begin
              // Publish the whole snapshot at once as DONE is entered
              state_q <= ST_DONE;
              cs_n_q  <= 1'b1;
              data_q  <= stage_q;
              dv_q    <= 1'b1;
            end else begin
              w_q    <= w_q + WW'(1);
              rd_n_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        ST_DONE: begin
          state_q <= ST_QUIET;
          cnt_q   <= 32'd0;
        end
        ST_QUIET: begin
          if (cnt_q == 32'(T_QUIET - 1)) begin
            state_q <= ST_IDLE;
            cnt_q   <= 32'd0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign convst_o     = convst_q;
  assign cs_n_o       = cs_n_q;
  assign rd_n_o       = rd_n_q;
  assign adc_reset_o  = arst_q;
  assign data_o       = data_q;
  assign data_valid_o = dv_q;
  assign timeout_o    = timeout_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_ad76xx_par_reader.sv
// Directed bench for ad76xx_par_reader: default 6x16 instance plus an 8x14 one.
module tb_ad76xx_par_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i, start_i, start2;
  logic          busy_i, busy2;
  logic [15:0]   db_i;
  logic [13:0]   db2;
  logic          convst_o, cs_n_o, rd_n_o, adc_reset_o, data_valid_o, timeout_o, overrun_o;
  logic [95:0]   data_o;
  logic          convst2, cs_n2, rd_n2, arst2, dv2, tmo2, ovr2;
  logic [111:0]  data2;
`ifdef AD76XX_AUTO_TRIG_EN
  logic [31:0]   trig_div, trig_div2;
`endif

  ad76xx_par_reader dut (
    .sys_clk_i(clk), .rst_i(rst_i), .start_i(start_i),
`ifdef AD76XX_AUTO_TRIG_EN
    .trig_div_i(trig_div),
`endif
    .convst_o(convst_o), .busy_i(busy_i), .cs_n_o(cs_n_o), .rd_n_o(rd_n_o),
    .adc_reset_o(adc_reset_o), .db_i(db_i), .data_o(data_o),
    .data_valid_o(data_valid_o), .timeout_o(timeout_o), .overrun_o(overrun_o)
  );

  ad76xx_par_reader #(.DW(14), .NUM_CH(8), .T_RDL(4)) dut2 (
    .sys_clk_i(clk), .rst_i(rst_i), .start_i(start2),
`ifdef AD76XX_AUTO_TRIG_EN
    .trig_div_i(trig_div2),
`endif
    .convst_o(convst2), .busy_i(busy2), .cs_n_o(cs_n2), .rd_n_o(rd_n2),
    .adc_reset_o(arst2), .db_i(db2), .data_o(data2),
    .data_valid_o(dv2), .timeout_o(tmo2), .overrun_o(ovr2)
  );

  // Bench-side ADC behaviour and observation
  int          busy_cyc = 200;
  logic        busy_en  = 1'b1;
  logic [15:0] db_base  = 16'h0;
  int burst_w = 0, burst_w2 = 0;
  assign db_i = db_base + 16'(burst_w);
  assign db2  = 14'h2000 + 14'(burst_w2);

  // ADC model: BUSY rises after CONVST and falls busy_cyc cycles later
  initial begin
    int left, left2;
    logic cp, cp2;
    busy_i = 1'b0; busy2 = 1'b0; left = 0; left2 = 0; cp = 1'b0; cp2 = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (convst_o === 1'b1 && !cp && busy_en) begin busy_i = 1'b1; left = busy_cyc; end
      else if (left > 0) begin left--; if (left == 0) busy_i = 1'b0; end
      if (convst2 === 1'b1 && !cp2) begin busy2 = 1'b1; left2 = busy_cyc; end
      else if (left2 > 0) begin left2--; if (left2 == 0) busy2 = 1'b0; end
      cp = (convst_o === 1'b1); cp2 = (convst2 === 1'b1);
    end
  end

  int cyc = 0, dv_tot = 0, ovr_tot = 0, tmo_tot = 0, rdp_tot = 0, bad_rdl = 0, bad_conv = 0;
  int rd_run = 0, conv_run = 0, cs_run = 0, cs_len = 0, sf = 999, lat = 999;
  int dv_last = -1, dv_intv = 0;
  int dv2_tot = 0, rdp2_tot = 0, bad_rdl2 = 0, rd2_run = 0;
  logic rd_prev = 1'b1, cs_prev = 1'b1, busy_prev = 1'b0, conv_prev = 1'b0;
  logic rd2_prev = 1'b1;

  // Monitor sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    cyc++;
    if (data_valid_o === 1'b1) begin
      dv_tot++;
      if (dv_last >= 0) dv_intv = cyc - dv_last;
      dv_last = cyc;
    end
    if (overrun_o === 1'b1) ovr_tot++;
    if (timeout_o === 1'b1) tmo_tot++;
    if (rd_n_o === 1'b0) rd_run++;
    else if (rd_prev === 1'b0) begin rdp_tot++; if (rd_run != 9) bad_rdl++; rd_run = 0; end
    if (convst_o === 1'b1) conv_run++;
    else if (conv_prev === 1'b1) begin if (conv_run != 4) bad_conv++; conv_run = 0; end
    if (busy_prev === 1'b1 && busy_i === 1'b0) sf = 0; else sf++;
    if (cs_n_o === 1'b0) begin
      if (cs_prev === 1'b1) lat = sf;
      cs_run++;
    end else if (cs_prev === 1'b0) begin cs_len = cs_run; cs_run = 0; end
    if (cs_n_o !== 1'b0) burst_w = 0;
    else if (rd_prev === 1'b0 && rd_n_o === 1'b1) burst_w++;
    rd_prev = rd_n_o; cs_prev = cs_n_o; busy_prev = busy_i; conv_prev = convst_o;
    if (dv2 === 1'b1) dv2_tot++;
    if (rd_n2 === 1'b0) rd2_run++;
    else if (rd2_prev === 1'b0) begin rdp2_tot++; if (rd2_run != 4) bad_rdl2++; rd2_run = 0; end
    if (cs_n2 !== 1'b0) burst_w2 = 0;
    else if (rd2_prev === 1'b0 && rd_n2 === 1'b1) burst_w2++;
    rd2_prev = rd_n2;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1; tick(); start_i = 1'b0;
  endtask

  typedef struct {
    int          busy;
    logic [15:0] base;
    logic [95:0] exp;
  } vec_t;
  vec_t vec [4];

  // One full conversion; mid=1 fires a second start during word 2
  task automatic run_vec(input int i, input bit mid);
    int dv0, rd0, brd0, bcv0, ov0, n;
    bit fired;
    dv0 = dv_tot; rd0 = rdp_tot; brd0 = bad_rdl; bcv0 = bad_conv; ov0 = ovr_tot;
    db_base = vec[i].base; busy_cyc = vec[i].busy; fired = 0; n = 0;
    pulse_start();
    chk($sformatf("v%0d_convst_lat", i), convst_o, 1'b1);
    while (data_valid_o !== 1'b1 && n < 3000) begin
      start_i = mid && !fired && cs_n_o === 1'b0 && burst_w == 2;
      if (start_i) fired = 1;
      tick(); n++;
    end
    start_i = 1'b0;
    chk($sformatf("v%0d_dv_seen", i), data_valid_o, 1'b1);
    chk($sformatf("v%0d_data", i), data_o, vec[i].exp);
    repeat (12) tick();
    chk($sformatf("v%0d_dv_count", i), dv_tot - dv0, 1);
    chk($sformatf("v%0d_rd_pulses", i), rdp_tot - rd0, 6);
    chk($sformatf("v%0d_rd_low_width", i), bad_rdl - brd0, 0);
    chk($sformatf("v%0d_convst_width", i), bad_conv - bcv0, 0);
    chk($sformatf("v%0d_cs_len", i), cs_len, 77);
    chk($sformatf("v%0d_busy_to_cs", i), (lat >= 1 && lat <= 3), 1'b1);
    chk($sformatf("v%0d_overrun", i), ovr_tot - ov0, mid ? 1 : 0);
  endtask

  initial begin
    int n, ov0, dv0, tm0;
    rst_i = 1'b1; start_i = 1'b0; start2 = 1'b0;
`ifdef AD76XX_AUTO_TRIG_EN
    trig_div = 32'd0; trig_div2 = 32'd0;
`endif
    vec[0] = '{200, 16'h1000, 96'h1005_1004_1003_1002_1001_1000};
    vec[1] = '{20,  16'hFFFB, 96'h0000_FFFF_FFFE_FFFD_FFFC_FFFB};
    vec[2] = '{5,   16'h7FFE, 96'h8003_8002_8001_8000_7FFF_7FFE};
    vec[3] = '{60,  16'h0A5A, 96'h0A5F_0A5E_0A5D_0A5C_0A5B_0A5A};

    repeat (3) tick();
    chk("rst_outputs", {convst_o, cs_n_o, rd_n_o, adc_reset_o, data_valid_o, timeout_o, overrun_o},
        7'b0111000);
    chk("rst_data", data_o, 96'h0);
    rst_i = 1'b0;
    n = 0;
    while (adc_reset_o === 1'b1 && n < 50) begin tick(); n++; end
    chk("adc_reset_hold", n, 10);

    run_vec(0, 0);
    run_vec(1, 0);

    // BUSY never moves: timeout after BUSY_TMO cycles, snapshot untouched
    busy_en = 1'b0; dv0 = dv_tot; tm0 = tmo_tot;
    pulse_start();
    n = 0;
    while (timeout_o !== 1'b1 && n < 1000) begin tick(); n++; end
    chk("tmo_cycle", n, 400);
    tick();
    chk("tmo_pulse_width", timeout_o, 1'b0);
    chk("tmo_data_kept", data_o, vec[1].exp);
    chk("tmo_no_dv", dv_tot - dv0, 0);
    chk("tmo_count", tmo_tot - tm0, 1);
    chk("tmo_lines_idle", {convst_o, cs_n_o, rd_n_o}, 3'b011);
    repeat (5) tick();
    busy_en = 1'b1;

    run_vec(2, 1);

    // Reset during word 3: partial read must not reach data_o
    db_base = 16'h5555; busy_cyc = 30;
    pulse_start();
    n = 0;
    while (!(burst_w == 3 && rd_n_o === 1'b0) && n < 1000) begin tick(); n++; end
    chk("mid_rst_reached_w3", (burst_w == 3), 1'b1);
    ov0 = ovr_tot; dv0 = dv_tot;
    rst_i = 1'b1; tick();
    chk("mid_rst_lines", {cs_n_o, rd_n_o, convst_o, adc_reset_o}, 4'b1101);
    chk("mid_rst_data", data_o, 96'h0);
    rst_i = 1'b0;
    n = 0;
    while (adc_reset_o === 1'b1 && n < 50) begin
      start_i = (n == 2);
      tick(); n++;
    end
    start_i = 1'b0;
    chk("mid_rst_adc_reset_hold", n, 10);
    repeat (3) tick();
    chk("mid_rst_start_ignored", convst_o, 1'b0);
    chk("mid_rst_no_overrun", ovr_tot - ov0, 0);
    chk("mid_rst_no_dv", dv_tot - dv0, 0);

    run_vec(3, 0);

    // Wide configuration: 8 channels of 14 bits
    dv0 = dv2_tot; ov0 = rdp2_tot; tm0 = bad_rdl2; busy_cyc = 40;
    start2 = 1'b1; tick(); start2 = 1'b0;
    n = 0;
    while (dv2 !== 1'b1 && n < 2000) begin tick(); n++; end
    chk("w8_data", data2, {14'h2007, 14'h2006, 14'h2005, 14'h2004,
                           14'h2003, 14'h2002, 14'h2001, 14'h2000});
    repeat (12) tick();
    chk("w8_dv_count", dv2_tot - dv0, 1);
    chk("w8_rd_pulses", rdp2_tot - ov0, 8);
    chk("w8_rd_low_width", bad_rdl2 - tm0, 0);

`ifdef AD76XX_AUTO_TRIG_EN
    // Periodic trigger slow enough to never overrun
    busy_cyc = 150; db_base = 16'h0100;
    ov0 = ovr_tot; dv0 = dv_tot;
    trig_div = 32'd2000;
    n = 0;
    while (dv_tot - dv0 < 4 && n < 12000) begin tick(); n++; end
    chk("auto_dv_seen", dv_tot - dv0, 4);
    chk("auto_period", dv_intv, 2000);
    chk("auto_no_overrun", ovr_tot - ov0, 0);
    chk("auto_data", data_o, 96'h0105_0104_0103_0102_0101_0100);
    // Period shorter than a conversion: triggers landing mid-read are dropped
    ov0 = ovr_tot; dv0 = dv_tot;
    trig_div = 32'd100;
    repeat (1000) tick();
    chk("auto_fast_overrun", (ovr_tot - ov0) > 0, 1'b1);
    chk("auto_fast_dv", (dv_tot - dv0) > 0, 1'b1);
    trig_div = 32'd0;
    repeat (400) tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
